// File: rtl/lut_sched_pkg.sv
// lut_sched_pkg
//   Shared definitions for the LUT layer scheduler: width helper functions,
//   the scheduler state encoding and the configuration-select encoding.
//   Ports: none (package).
package lut_sched_pkg;

    // Table address width: one IN_BITS activation per fan-in input.
    function automatic int addr_w(input int fanin, input int in_bits);
        return fanin * in_bits;
    endfunction

    // Width of an input-activation index.
    function automatic int idx_w(input int num_inputs);
        return $clog2(num_inputs);
    endfunction

    // Width of a neuron id.
    function automatic int nid_w(input int num_neurons);
        return $clog2(num_neurons);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Width of the fan-in slot field in a connectivity config address.
    localparam int CFG_K_W = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        DRAIN  = 2'd2,
        OUTPUT = 2'd3
    } state_t;

    typedef enum logic {
        CFG_TABLE = 1'b0,
        CFG_CONN  = 1'b1
    } cfg_sel_t;

endpackage

// File: rtl/lut_sched_ram.sv
// lut_sched_ram
//   Shared truth-table storage: 2^AW entries of DW bits, one write port and
//   one synchronous read port (1-cycle read latency). Contents are not reset.
//   Ports:
//     clk    in   clock
//     we     in   write enable
//     waddr  in   write address
//     wdata  in   write data
//     re     in   read enable
//     raddr  in   read address
//     rdata  out  registered read data
module lut_sched_ram #(
    parameter int AW = 9,
    parameter int DW = 2
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    (* ram_style = "distributed", rom_style = "distributed" *)
    logic [DW-1:0] mem [2**AW];

    // NOTE: the array has no reset branch; resetting a memory turns it into
    // thousands of flops and blocks RAM inference, and the table is always
    // written before it is meaningfully read.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/lut_layer_scheduler.sv
// lut_layer_scheduler
//   Evaluates all neurons of a quantised LUT layer serially through one shared,
//   run-time-writable truth-table RAM. One input vector in, one packed output
//   vector out, NUM_NEURONS+3 cycles minimum per vector.
//   Optional feature macro: LUT_SCHED_STATS_EN adds vec_count / stall_count.
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     in_valid/in_ready     input vector handshake, in_data activations
//     out_valid/out_ready   output vector handshake, out_data neuron results
//     cfg_we/cfg_sel        config write strobe, 0=table entry 1=connectivity
//     cfg_addr/cfg_wdata    config address / data
//     cfg_ready             config write accepted (IDLE only)
//     vec_count             (stats) saturating count of output handshakes
//     stall_count           (stats) saturating count of OUTPUT cycles stalled
module lut_layer_scheduler
    import lut_sched_pkg::*;
#(
    parameter int NUM_NEURONS = 8,
    parameter int NUM_INPUTS  = 16,
    parameter int FANIN       = 3,
    parameter int IN_BITS     = 2,
    parameter int OUT_BITS    = 2,
    localparam int ADDR_W  = addr_w(FANIN, IN_BITS),
    localparam int IDX_W   = idx_w(NUM_INPUTS),
    localparam int NID_W   = nid_w(NUM_NEURONS),
    localparam int WDATA_W = max2(OUT_BITS, IDX_W)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [NUM_INPUTS*IN_BITS-1:0]   in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_NEURONS*OUT_BITS-1:0] out_data,
    input  logic                            cfg_we,
    input  logic                            cfg_sel,
    input  logic [NID_W+ADDR_W-1:0]         cfg_addr,
    input  logic [WDATA_W-1:0]              cfg_wdata,
    output logic                            cfg_ready
`ifdef LUT_SCHED_STATS_EN
   ,output logic [15:0]                     vec_count,
    output logic [15:0]                     stall_count
`endif
);

    localparam logic [NID_W:0] NID_LAST = (NID_W+1)'(NUM_NEURONS - 1);

    state_t state_q, state_d;

    logic [NUM_INPUTS-1:0][IN_BITS-1:0]   in_q;
    logic [NUM_NEURONS-1:0][OUT_BITS-1:0] out_q;
    logic [IDX_W-1:0]                     conn_q [NUM_NEURONS][FANIN];
    logic [NID_W:0]                       nid_q;   // extra bit: terminal compare never wraps
    logic                                 rd_pend_q;
    logic [NID_W-1:0]                     rd_lane_q;

    logic [FANIN-1:0][IN_BITS-1:0] tbl_addr;
    logic [OUT_BITS-1:0]           rd_data;
    logic                          accept, cfg_acc, tbl_we, conn_we;
    logic [NID_W-1:0]              conn_nid;
    logic [CFG_K_W-1:0]            conn_k;

    // ---------------- configuration decode ----------------
    assign accept   = in_valid && in_ready;
    assign cfg_acc  = cfg_we && cfg_ready;
    assign conn_nid = cfg_addr[NID_W+CFG_K_W-1:CFG_K_W];
    assign conn_k   = cfg_addr[CFG_K_W-1:0];
    assign tbl_we   = cfg_acc && (cfg_sel_t'(cfg_sel) == CFG_TABLE);
    // Out-of-range slot or input index: write is silently ignored.
    assign conn_we  = cfg_acc && (cfg_sel_t'(cfg_sel) == CFG_CONN)
                      && (32'(conn_k) < FANIN) && (32'(cfg_wdata) < NUM_INPUTS);

    // ---------------- FSM ----------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: next-state gets a default before the case so no path leaves it
    // unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)             state_d = ISSUE;
            ISSUE:   if (nid_q == NID_LAST)  state_d = DRAIN;
            DRAIN:                           state_d = OUTPUT;
            OUTPUT:  if (out_ready)          state_d = IDLE;
            default:                         state_d = IDLE;
        endcase
    end

    // rst_n gates the handshakes so nothing is accepted while reset is held.
    always_comb begin
        in_ready  = 1'b0;
        cfg_ready = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                cfg_ready = rst_n;
                in_ready  = rst_n && !cfg_we;   // config write wins the cycle
            end
            OUTPUT:  out_valid = 1'b1;
            default: ;
        endcase
    end

    // ---------------- address gather ----------------
    // Fan-in slot k lands at bits [k*IN_BITS +: IN_BITS]; slot FANIN-1 is the MSBs.
    always_comb begin
        tbl_addr = '0;
        for (int k = 0; k < FANIN; k++)
            tbl_addr[k] = in_q[conn_q[nid_q[NID_W-1:0]][k]];
    end

    lut_sched_ram #(
        .AW(NID_W + ADDR_W),
        .DW(OUT_BITS)
    ) u_ram (
        .clk   (clk),
        .we    (tbl_we),
        .waddr (cfg_addr),
        .wdata (cfg_wdata[OUT_BITS-1:0]),
        .re    (state_q == ISSUE),
        .raddr ({nid_q[NID_W-1:0], tbl_addr}),
        .rdata (rd_data)
    );

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q      <= '0;
            nid_q     <= '0;
            out_q     <= '0;
            rd_pend_q <= 1'b0;
            rd_lane_q <= '0;
        end else begin
            if (state_q == IDLE && accept) begin
                in_q  <= in_data;
                nid_q <= '0;
            end else if (state_q == ISSUE) begin
                nid_q <= nid_q + 1'b1;
            end
            // Remember which lane the read just issued belongs to; its data
            // arrives one cycle later (the last one lands during DRAIN).
            rd_pend_q <= (state_q == ISSUE);
            rd_lane_q <= nid_q[NID_W-1:0];
            if (rd_pend_q) out_q[rd_lane_q] <= rd_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < NUM_NEURONS; n++)
                for (int k = 0; k < FANIN; k++)
                    conn_q[n][k] <= IDX_W'((n * FANIN + k) % NUM_INPUTS);
        end else if (conn_we) begin
            conn_q[conn_nid][conn_k] <= cfg_wdata[IDX_W-1:0];
        end
    end

    assign out_data = out_q;

`ifdef LUT_SCHED_STATS_EN
    logic [15:0] vec_q, stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q   <= '0;
            stall_q <= '0;
        end else begin
            if (out_valid && out_ready && vec_q != 16'hFFFF)
                vec_q <= vec_q + 16'd1;
            if (state_q == OUTPUT && !out_ready && stall_q != 16'hFFFF)
                stall_q <= stall_q + 16'd1;
        end
    end

    assign vec_count   = vec_q;
    assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_lut_layer_scheduler.sv
// tb_lut_layer_scheduler
//   Directed bench for lut_layer_scheduler with a reference model of the
//   truth tables and connectivity and a scoreboard queue of expected vectors.
//   Define LUT_SCHED_STATS_EN to also check the statistics counters.
module tb_lut_layer_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        cfg_we;
    logic        cfg_sel;
    logic [8:0]  cfg_addr;
    logic [3:0]  cfg_wdata;
    logic        cfg_ready;
`ifdef LUT_SCHED_STATS_EN
    logic [15:0] vec_count;
    logic [15:0] stall_count;
`endif

    lut_layer_scheduler dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .cfg_we     (cfg_we),
        .cfg_sel    (cfg_sel),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .cfg_ready  (cfg_ready)
`ifdef LUT_SCHED_STATS_EN
       ,.vec_count  (vec_count),
        .stall_count(stall_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int acc_cyc;

    logic [1:0]  m_tbl  [8][64];
    logic [3:0]  m_conn [8][3];
    logic [15:0] sb [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic conn_default();
        for (int n = 0; n < 8; n++)
            for (int k = 0; k < 3; k++)
                m_conn[n][k] = 4'((n * 3 + k) % 16);
    endtask

    function automatic logic [5:0] addr_of(input int n, input logic [31:0] d);
        logic [5:0] a;
        for (int k = 0; k < 3; k++)
            a[k*2 +: 2] = d[int'(m_conn[n][k]) * 2 +: 2];
        return a;
    endfunction

    function automatic logic [15:0] model(input logic [31:0] d);
        logic [15:0] r;
        for (int n = 0; n < 8; n++)
            r[n*2 +: 2] = m_tbl[n][addr_of(n, d)];
        return r;
    endfunction

    // One-cycle config write, issued only while the DUT is known to be IDLE.
    task automatic cfg_write(input logic sel, input logic [8:0] addr, input logic [3:0] data);
        @(negedge clk);
        cfg_we = 1'b1; cfg_sel = sel; cfg_addr = addr; cfg_wdata = data;
        if (!sel)                m_tbl[addr[8:6]][addr[5:0]] = data[1:0];
        else if (addr[1:0] < 3)  m_conn[addr[4:2]][addr[1:0]] = data;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic load_table(input int mode);
        for (int n = 0; n < 8; n++)
            for (int a = 0; a < 64; a++) begin
                logic [5:0] av;
                logic [2:0] nv;
                logic [1:0] v;
                av = 6'(a); nv = 3'(n);
                if (mode == 0) v = av[1:0] ^ nv[1:0];
                else           v = av[1:0] ^ av[3:2] ^ av[5:4] ^ {nv[2], nv[0]};
                cfg_write(1'b0, {nv, av}, {2'b00, v});
            end
    endtask

    task automatic send(input logic [31:0] d);
        int n;
        @(negedge clk);
        in_valid = 1'b1; in_data = d;
        #1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk); #1; n++;
        end
        check("in_ready_accept", in_ready, 1);
        acc_cyc = cyc;
        sb.push_back(model(d));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // stall>0: caller has out_ready low; hold it for that many OUTPUT cycles.
    task automatic recv(input int stall);
        int n;
        logic [15:0] exp;
        n = 0;
        do begin
            @(negedge clk); n++;
        end while (!out_valid && n < 40);
        check("out_valid_rise", out_valid, 1);
        check("latency", cyc - acc_cyc, 10);
        exp = (sb.size() > 0) ? sb.pop_front() : 16'hxxxx;
        check("out_data", out_data, exp);
        if (stall > 0) begin
            for (int i = 1; i < stall; i++) begin
                @(negedge clk);
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, exp);
                check("hold_in_ready", in_ready, 0);
                check("hold_cfg_ready", cfg_ready, 0);
            end
            out_ready = 1'b1;
        end
        @(negedge clk);
        check("idle_out_valid", out_valid, 0);
        check("idle_in_ready", in_ready, 1);
    endtask

    initial begin
        logic [31:0] d;
        logic [5:0]  a;
        logic [1:0]  nv;
        int          n;

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        conn_default();
        #12;
        check("rst_in_ready", in_ready, 0);
        check("rst_cfg_ready", cfg_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        @(negedge clk); rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_cfg_ready", cfg_ready, 1);

        // 1) xor tables, default connectivity, E4 patterns
        load_table(0);
        send({4{8'hE4}});          recv(0);
        send(32'h0000_00E4);       recv(0);
        send(32'h1B1B_E4E4);       recv(0);

        // richer tables exercise every address bit
        load_table(1);
        send(32'h8D3C_71E4);       recv(0);

        // 2) 20-cycle output stall
        out_ready = 1'b0;
        send(32'hC3A5_5A3C);       recv(20);

        // connectivity writes, including ignored slot 3
        cfg_write(1'b1, {4'b0, 3'd5, 2'd2}, 4'd9);
        cfg_write(1'b1, {4'b0, 3'd5, 2'd3}, 4'd1);
        cfg_write(1'b1, {4'b0, 3'd0, 2'd0}, 4'd15);
        send(32'h9F00_0C06);       recv(0);

        for (int i = 0; i < 6; i++) begin
            cfg_write(1'b0, 9'($urandom), 4'($urandom));
            cfg_write(1'b1, 9'($urandom_range(0, 31)), 4'($urandom));
            send($urandom);        recv(0);
        end

        // 3) simultaneous config write and vector: write wins, vector next cycle
        d = 32'h6B2E_D417;
        a = addr_of(0, d);
        nv = m_tbl[0][a] ^ 2'b11;
        @(negedge clk);
        in_valid = 1'b1; in_data = d;
        cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = {3'd0, a}; cfg_wdata = {2'b00, nv};
        #1;
        check("sim_in_ready", in_ready, 0);
        check("sim_cfg_ready", cfg_ready, 1);
        m_tbl[0][a] = nv;
        @(negedge clk);
        cfg_we = 1'b0;
        #1;
        check("sim_in_ready_next", in_ready, 1);
        acc_cyc = cyc;
        sb.push_back(model(d));
        @(posedge clk); #1;
        in_valid = 1'b0;
        recv(0);

        // 4) config write during ISSUE is dropped
        send(32'h0123_4567);
        cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = {3'd0, 6'h3F}; cfg_wdata = {2'b00, ~m_tbl[0][63]};
        #1;
        check("issue_cfg_ready", cfg_ready, 0);
        @(posedge clk); #1;
        cfg_we = 1'b0;
        recv(0);
        send(32'hFFFF_FFFF);       recv(0);

        // 5a) reset during ISSUE at nid=4
        send(32'hA5A5_0FF0);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_issue_out_valid", out_valid, 0);
        check("rst_issue_in_ready", in_ready, 0);
        check("rst_issue_out_data", out_data, 0);
        sb.delete();
        conn_default();
        @(negedge clk); rst_n = 1'b1;
        send(32'h5E21_B7C9);       recv(0);

        // 5b) reset while holding OUTPUT drops out_valid immediately
        out_ready = 1'b0;
        send(32'h3344_5566);
        n = 0;
        do begin
            @(negedge clk); n++;
        end while (!out_valid && n < 40);
        check("pre_rst_out_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("rst_output_out_valid", out_valid, 0);
        sb.delete();
        conn_default();
        out_ready = 1'b1;
        @(negedge clk); rst_n = 1'b1;

        // 6) three vectors after reset, five stall cycles in total
        send(32'hDEAD_BEEF);       recv(0);
        out_ready = 1'b0;
        send(32'h0F1E_2D3C);       recv(5);
        send(32'h7777_1234);       recv(0);
`ifdef LUT_SCHED_STATS_EN
        check("vec_count", vec_count, 3);
        check("stall_count", stall_count, 5);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
